// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU front-end sequencer.
// State encodings are visible on state_o, so their values are fixed here.
package alu_seq_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  typedef enum logic [2:0] {
    ST_GET_A  = 3'd0,
    ST_GET_B  = 3'd1,
    ST_GET_OP = 3'd2,
    ST_EXEC   = 3'd3,
    ST_SHOW   = 3'd4
  } state_e;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Operand/result link between the sequencer (master) and the ALU (slave).
// The ALU is combinational, so result and flags track the operands directly.
interface alu_operand_sequencer_if
  import alu_seq_pkg::*;
();

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_sel;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_carry;

  modport master (
    output alu_a, alu_b, alu_sel,
    input  alu_result, alu_zero, alu_carry
  );

  modport slave (
    input  alu_a, alu_b, alu_sel,
    output alu_result, alu_zero, alu_carry
  );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer, stability counter and registered one-cycle pulse
// on each accepted low-to-high transition of a raw push button.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_prev_q;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    pulse_d = level_q & ~level_prev_q;
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch and is
  // not in the sensitivity list; non-blocking assignments keep all flops
  // updating from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      pulse_q      <= pulse_d;
      cnt_q        <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Board-side controller: collects A, B and op from the switches, drives the
// ALU, latches its result and flags, and shows them on the LEDs.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [DATA_W-1:0]      sw,
  input  logic                   btn_load,
  input  logic                   btn_clear,
  alu_operand_sequencer_if.master alu,
  output logic [DATA_W-1:0]      leds,
  output logic [1:0]             flags,
  output logic                   done,
  output logic [2:0]             state_o
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0] leds_q, leds_d;
  logic [1:0]        flags_q, flags_d;
  logic              done_q, done_d;
  logic              clr_sync1_q, clr_sync2_q;
  logic              load_pulse;
  logic              press;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_load_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_load),
    .pulse_o(load_pulse)
  );

  assign press = load_pulse & ena;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    leds_d  = leds_q;
    flags_d = flags_q;
    done_d  = done_q;
    unique case (state_q)
      ST_GET_A: begin
        leds_d = sw;
        if (press) begin
          a_d     = sw;
          state_d = ST_GET_B;
        end
      end
      ST_GET_B: begin
        leds_d = sw;
        if (press) begin
          b_d     = sw;
          state_d = ST_GET_OP;
        end
      end
      ST_GET_OP: begin
        leds_d = sw;
        if (press) begin
          sel_d   = sw[OP_W-1:0];
          state_d = ST_EXEC;
        end
      end
      // Operands were registered last cycle, so the ALU output is settled now.
      ST_EXEC: begin
        leds_d  = alu.alu_result;
        flags_d = {alu.alu_carry, alu.alu_zero};
        done_d  = 1'b1;
        state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (press) begin
          done_d  = 1'b0;
          state_d = ST_GET_A;
        end
      end
      default: state_d = ST_GET_A;
    endcase
    // Clear is a level and overrides any press or enable in the same cycle.
    if (clr_sync2_q) begin
      state_d = ST_GET_A;
      a_d     = '0;
      b_d     = '0;
      sel_d   = '0;
      flags_d = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_GET_A;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      leds_q      <= '0;
      flags_q     <= '0;
      done_q      <= 1'b0;
      clr_sync1_q <= 1'b0;
      clr_sync2_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      leds_q      <= leds_d;
      flags_q     <= flags_d;
      done_q      <= done_d;
      clr_sync1_q <= btn_clear;
      clr_sync2_q <= clr_sync1_q;
    end
  end

  assign alu.alu_a   = a_q;
  assign alu.alu_b   = b_q;
  assign alu.alu_sel = sel_q;
  assign leds        = leds_q;
  assign flags       = flags_q;
  assign done        = done_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with an XOR ALU stub and a
// scoreboard of expected display values/flags.
module tb_alu_operand_sequencer;

  localparam int DEB = 4;

  typedef struct packed {
    logic [7:0] leds;
    logic [1:0] flags;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, ena, btn_load, btn_clear;
  logic [7:0] sw;
  logic [7:0] leds;
  logic [1:0] flags;
  logic       done;
  logic [2:0] state_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  alu_operand_sequencer_if alu_bus ();

  assign alu_bus.alu_result = alu_bus.alu_a ^ alu_bus.alu_b;
  assign alu_bus.alu_zero   = (alu_bus.alu_result == 8'h00);
  assign alu_bus.alu_carry  = alu_bus.alu_sel[0];

  alu_operand_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .sw       (sw),
    .btn_load (btn_load),
    .btn_clear(btn_clear),
    .alu      (alu_bus),
    .leds     (leds),
    .flags    (flags),
    .done     (done),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Press long enough to be accepted, then release long enough for the
  // release to be accepted so the next press is a fresh event.
  task automatic do_press();
    btn_load = 1'b1;
    tick(DEB + 4);
    btn_load = 1'b0;
    tick(DEB + 4);
  endtask

  // Op press: push the model result, then wait (bounded) for done and score it.
  task automatic op_press(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
    exp_t e;
    int   n;
    e.leds  = a ^ b;
    e.flags = {sel[0], (a ^ b) == 8'h00};
    sb_q.push_back(e);
    btn_load = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    check("done_latency", n, DEB + 5);
    check("done_high", done, 1);
    check("state_show", state_o, 4);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check("leds_result", leds, e.leds);
      check("flags_result", flags, e.flags);
    end
    btn_load = 1'b0;
    tick(DEB + 4);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; sw = 8'h00; btn_load = 1'b0; btn_clear = 1'b0;
    tick(2);
    check("rst_alu_a", alu_bus.alu_a, 0);
    check("rst_alu_b", alu_bus.alu_b, 0);
    check("rst_alu_sel", alu_bus.alu_sel, 0);
    check("rst_leds", leds, 0);
    check("rst_flags", flags, 0);
    check("rst_done", done, 0);
    check("rst_state", state_o, 0);
    rst_n = 1'b1;
    tick(2);

    // Full sequence
    sw = 8'h2A; do_press();
    check("seq_state_b", state_o, 1);
    check("seq_alu_a", alu_bus.alu_a, 8'h2A);
    check("seq_echo", leds, 8'h2A);
    sw = 8'h05; do_press();
    check("seq_state_op", state_o, 2);
    check("seq_alu_b", alu_bus.alu_b, 8'h05);
    sw = 8'h01;
    op_press(8'h2A, 8'h05, 3'b001);
    check("seq_alu_sel", alu_bus.alu_sel, 1);
    sw = 8'h55; tick(3);
    check("show_hold_leds", leds, 8'h2F);
    do_press();
    check("show_exit_state", state_o, 0);
    check("show_exit_done", done, 0);
    check("echo_after_show", leds, 8'h55);

    // Bounce then long hold
    sw = 8'h33;
    for (int i = 0; i < 6; i++) begin
      btn_load = ~i[0];
      tick(2);
    end
    check("bounce_no_advance", state_o, 0);
    btn_load = 1'b1;
    tick(DEB + 3);
    check("hold_before_edge7", state_o, 0);
    tick(1);
    check("hold_at_edge7", state_o, 1);
    check("hold_alu_a", alu_bus.alu_a, 8'h33);
    tick(100);
    check("long_hold_one_adv", state_o, 1);
    btn_load = 1'b0;
    tick(DEB + 4);
    check("long_hold_release", state_o, 1);

    // Zero result
    do_press();
    check("zero_state_op", state_o, 2);
    sw = 8'h02;
    op_press(8'h33, 8'h33, 3'b010);
    check("zero_flag", flags[0], 1);
    do_press();

    // Clear coincident with an op press pulse
    sw = 8'h11; do_press();
    sw = 8'h22; do_press();
    check("clr_pre_state", state_o, 2);
    sw = 8'h07;
    btn_load = 1'b1;
    tick(DEB + 1);
    btn_clear = 1'b1;
    tick(2);
    check("clr_not_yet", state_o, 2);
    tick(1);
    check("clr_state", state_o, 0);
    check("clr_alu_a", alu_bus.alu_a, 0);
    check("clr_alu_b", alu_bus.alu_b, 0);
    check("clr_alu_sel", alu_bus.alu_sel, 0);
    check("clr_done", done, 0);
    btn_clear = 1'b0;
    btn_load  = 1'b0;
    tick(DEB + 4);
    check("clr_stays_get_a", state_o, 0);

    // ena low discards the press
    ena = 1'b0; sw = 8'h44;
    do_press();
    check("ena_no_advance", state_o, 0);
    check("ena_alu_a_kept", alu_bus.alu_a, 0);
    ena = 1'b1;

    // Reset in SHOW
    sw = 8'h0F; do_press();
    sw = 8'hF0; do_press();
    sw = 8'h01;
    op_press(8'h0F, 8'hF0, 3'b001);
    rst_n = 1'b0;
    tick(1);
    check("rst_show_done", done, 0);
    check("rst_show_leds", leds, 0);
    check("rst_show_state", state_o, 0);
    check("rst_show_flags", flags, 0);
    rst_n = 1'b1;
    tick(2);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
